uart_tx_feeder: RTL and testbench

- Buffered front-end that sits directly upstream of uart_tx.
- Accepts bytes from system logic over a valid/ready interface and stores them in a circular FIFO.
- Presents bytes one at a time to uart_tx through its data_word/enable/tx_active/tx_done interface, so back-to-back transmission needs no software pacing.
- Clock 10 MHz; baud timing belongs entirely to uart_tx.

---
 rtl/uart_tx_feeder.sv | 103 ++++++++++
 tb/tb_uart_tx_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: circular byte FIFO that paces bytes into uart_tx.
// Bytes arrive over valid/ready. Each byte is presented on tx_data/tx_enable
// until uart_tx reports tx_done, then a short idle gap follows.
module uart_tx_feeder #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_enable,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [GW-1:0]       gap_cnt;
  logic                done_q;
  logic                pending;   // tx_data holds a byte whose slot is still counted in level
  logic                done_rise;
  logic                wr_en;
  logic                pop;
  logic                gap_done;
  logic [LW-1:0]       level_nxt;

  assign done_rise = tx_done && !done_q;
  // flush drops any byte offered in the same cycle
  assign wr_en     = in_valid && in_ready && !flush;
  // a flush during SEND clears pending, so the later done_rise cannot pop
  // a byte written after the flush
  assign pop       = (state == SEND) && done_rise && pending && !flush;
  assign gap_done  = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign level_nxt = flush ? '0 : (level + LW'(wr_en) - LW'(pop));

  assign tx_enable = (state == SEND);
  assign busy      = (state != IDLE) || (level != '0);

  // FIFO storage; no reset needed, occupancy is tracked by level
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // pointers, occupancy, edge detect, output byte and gap counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b1;
      done_q   <= 1'b0;
      tx_data  <= '0;
      pending  <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      done_q   <= tx_done;
      level    <= level_nxt;
      in_ready <= (level_nxt != LW'(DEPTH));
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (state == LOAD && !flush) tx_data <= mem[rd_ptr];
      if (flush)                              pending <= 1'b0;
      else if (state == LOAD)                 pending <= 1'b1;
      else if (state == SEND && done_rise)    pending <= 1'b0;
      if (state == SEND && done_rise)         gap_cnt <= '0;
      else if (state == GAP && !gap_done)     gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (level != '0 && !flush) state_nxt = LOAD;
      LOAD: state_nxt = flush ? IDLE : SEND;
      SEND: if (done_rise) state_nxt = GAP;
      GAP:  if (gap_done && !tx_active) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a behavioural uart_tx consumes presented bytes
// and compares each completed frame against a queue of expected bytes.
module tb_uart_tx_feeder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int GAP    = 2;
  localparam int FRAME  = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_enable;
  logic             tx_active = 1'b0;
  logic             tx_done = 1'b0;
  logic [4:0]       level;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  logic [7:0] exp_q[$];

  uart_tx_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .tx_data(tx_data),
    .tx_enable(tx_enable), .tx_active(tx_active), .tx_done(tx_done),
    .level(level), .busy(busy)
  );

  always #50 clk = ~clk;

  // behavioural uart_tx: latch byte on enable, stay active FRAME cycles, pulse done
  logic [7:0] cap;
  int         fcnt = 0;
  int         low_cnt = 0;
  bit         seen_fall = 0;
  logic       en_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      tx_active = 1'b0; tx_done = 1'b0; fcnt = 0; seen_fall = 0; en_q = 1'b0;
    end else begin
      if (tx_enable && !en_q && seen_fall) begin
        checks++;
        if (low_cnt < GAP) begin
          errors++;
          $display("FAIL gap: %0d idle cycles, need >= %0d", low_cnt, GAP);
        end
      end
      if (!tx_enable) begin
        if (en_q) begin seen_fall = 1; low_cnt = 0; end
        low_cnt++;
      end
      en_q = tx_enable;
      if (tx_done) tx_done = 1'b0;
      else if (tx_active) begin
        checks++;
        if (tx_enable !== 1'b1 || tx_data !== cap) begin
          errors++;
          $display("FAIL hold: en=%b data=%h, want en=1 data=%h", tx_enable, tx_data, cap);
        end
        fcnt++;
        if (fcnt == FRAME) begin
          tx_active = 1'b0; tx_done = 1'b1; rx_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got %h, want nothing", cap);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (cap !== e) begin
              errors++;
              $display("FAIL rx_byte: got %h, want %h", cap, e);
            end
          end
        end
      end else if (tx_enable) begin
        cap = tx_data; tx_active = 1'b1; fcnt = 0;
      end
    end
  end

  // offer n consecutive bytes start, start+1, ...
  task automatic write_burst(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = start + 8'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 3000 && (busy || tx_active || tx_done || exp_q.size() != 0)) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b level=%0d pending=%0d, want idle", name, busy, level, exp_q.size());
    end
  endtask

  task automatic wait_enable(input string name);
    int n = 0;
    while (n < 100 && !tx_enable) begin @(negedge clk); n++; end
    checks++;
    if (!tx_enable) begin
      errors++;
      $display("FAIL %s_enable_timeout: tx_enable=%b, want 1", name, tx_enable);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || tx_enable !== 1'b0 || tx_data !== 8'h00 || level !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b en=%b data=%h lvl=%0d busy=%b, want 1 0 00 0 0",
               in_ready, tx_enable, tx_data, level, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int base = rx_count;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);            // write edge has passed
    in_valid = 1'b0;
    checks++;
    if (tx_enable !== 1'b0) begin errors++; $display("FAIL lat_e1: en=%b, want 0", tx_enable); end
    @(negedge clk);
    checks++;
    if (tx_enable !== 1'b0) begin errors++; $display("FAIL lat_e2: en=%b, want 0", tx_enable); end
    @(negedge clk);            // third rising edge counting the write edge
    checks++;
    if (tx_enable !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL lat_e3: en=%b data=%h, want 1 a5", tx_enable, tx_data);
    end
    wait_idle("single");
    checks++;
    if (level !== 5'd0 || busy !== 1'b0 || rx_count - base != 1) begin
      errors++; $display("FAIL single_end: lvl=%0d busy=%b rx=%0d, want 0 0 1", level, busy, rx_count - base);
    end
  endtask

  task automatic test_burst();
    int base = rx_count;
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    write_burst(8'h01, 16);
    checks++;
    if (in_ready !== 1'b0 || level !== 5'd16) begin
      errors++; $display("FAIL burst_full: rdy=%b lvl=%0d, want 0 16", in_ready, level);
    end
    wait_idle("burst");
    checks++;
    if (rx_count - base != 16) begin
      errors++; $display("FAIL burst_count: rx=%0d, want 16", rx_count - base);
    end
  endtask

  task automatic test_overflow();
    int base = rx_count;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h20 + 8'(i));
    write_burst(8'h20, 20);
    checks++;
    if (level !== 5'd16 || in_ready !== 1'b0) begin
      errors++; $display("FAIL overflow_level: lvl=%0d rdy=%b, want 16 0", level, in_ready);
    end
    wait_idle("overflow");
    checks++;
    if (rx_count - base != 16) begin
      errors++; $display("FAIL overflow_count: rx=%0d, want 16", rx_count - base);
    end
  endtask

  task automatic test_wrap();
    int base = rx_count;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h40 + 8'(r * 3 + i));
      write_burst(8'h40 + 8'(r * 3), 3);
      wait_idle("wrap");
    end
    checks++;
    if (rx_count - base != 30) begin
      errors++; $display("FAIL wrap_count: rx=%0d, want 30", rx_count - base);
    end
  endtask

  task automatic test_flush();
    int base = rx_count;
    exp_q.push_back(8'h11);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h11 * i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_enable("flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (level !== 5'd0 || tx_enable !== 1'b1) begin
      errors++; $display("FAIL flush_now: lvl=%0d en=%b, want 0 1", level, tx_enable);
    end
    wait_idle("flush");
    checks++;
    if (level !== 5'd0 || rx_count - base != 1) begin
      errors++; $display("FAIL flush_end: lvl=%0d rx=%0d, want 0 1", level, rx_count - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    write_burst(8'hA0, 4);
    wait_enable("rstmid");
    rst = 1'b1;
    #1;
    checks++;
    if (tx_enable !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid: en=%b lvl=%0d rdy=%b busy=%b, want 0 0 1 0",
                         tx_enable, level, in_ready, busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    base = rx_count;
    exp_q.push_back(8'h5A);
    write_burst(8'h5A, 1);
    wait_idle("rstmid");
    checks++;
    if (rx_count - base != 1 || level !== 5'd0) begin
      errors++; $display("FAIL rstmid_after: rx=%0d lvl=%0d, want 1 0", rx_count - base, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
